// File: rtl/axi_chan_slice_if.sv
// ============================================================================
// axi_channel - AXI4 five-channel bundle with master/slave modports.
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_channel #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_lock;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_qos;
  logic [3:0]          aw_region;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_lock;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_qos;
  logic [3:0]          ar_region;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

`default_nettype wire

// File: rtl/axi_chan_slice.sv
// ============================================================================
// axi_chan_slice - AXI4 channel slice, per-channel bypass/forward/skid stage.
// Optional SVA protocol checks: define AXI_CHAN_SLICE_ASSERT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module axi_chan_slice_stage #(
  parameter int MODE = 2,
  parameter int W    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  if (MODE == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dn_valid = up_valid;
    assign up_ready = dn_ready;
    assign dn_data  = up_data;
  end else if (MODE == 1) begin : g_fwd
    logic         vq_q, vq_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
      vq_d   = vq_q;
      data_d = data_q;
      if (up_valid && up_ready) begin
        vq_d   = 1'b1;
        data_d = up_data;
      end else if (dn_ready) begin
        vq_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vq_q   <= 1'b0;
        data_q <= '0;
      end else begin
        vq_q   <= vq_d;
        data_q <= data_d;
      end
    end

    assign up_ready = !vq_q || dn_ready;
    assign dn_valid = vq_q;
    assign dn_data  = data_q;
  end else begin : g_skid
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] m_q, m_d, s_q, s_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    assign push = up_valid && rdy_q;
    assign pop  = (state_q != EMPTY) && dn_ready;

    always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          m_d     = up_data;
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            s_d     = up_data;
          end else if (push) begin
            m_d = up_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        // ready is already low here, so only a pop can happen
        TWO: if (pop) begin
          state_d = ONE;
          m_d     = s_q;
        end
        default: state_d = EMPTY;
      endcase
      rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        m_q     <= '0;
        s_q     <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        m_q     <= m_d;
        s_q     <= s_d;
        rdy_q   <= rdy_d;
      end
    end

    assign up_ready = rdy_q;
    assign dn_valid = (state_q != EMPTY);
    assign dn_data  = m_q;

`ifdef AXI_CHAN_SLICE_ASSERT_EN
    a_occupancy: assert property (@(posedge clk) disable iff (rst)
      state_q inside {EMPTY, ONE, TWO});
`endif
  end

`ifdef AXI_CHAN_SLICE_ASSERT_EN
  a_up_hold: assert property (@(posedge clk) disable iff (rst)
    up_valid && !up_ready |=> up_valid);
  a_up_stable: assert property (@(posedge clk) disable iff (rst)
    up_valid && !up_ready |=> $stable(up_data));
  a_dn_hold: assert property (@(posedge clk) disable iff (rst)
    dn_valid && !dn_ready |=> dn_valid);
  a_dn_stable: assert property (@(posedge clk) disable iff (rst)
    dn_valid && !dn_ready |=> $stable(dn_data));
  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({up_valid, up_ready, dn_valid, dn_ready}));
`endif

endmodule

module axi_chan_slice #(
  parameter int AW_MODE = 2,
  parameter int W_MODE  = 2,
  parameter int B_MODE  = 2,
  parameter int AR_MODE = 2,
  parameter int R_MODE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  axi_channel.slave  master,
  axi_channel.master slave
);

  localparam int MID_W = $bits(master.aw_id);
  localparam int SID_W = $bits(slave.aw_id);
  localparam int AW_PW = SID_W + $bits(master.aw_addr) + 29 + $bits(master.aw_user);
  localparam int AR_PW = SID_W + $bits(master.ar_addr) + 29 + $bits(master.ar_user);
  localparam int W_PW  = $bits(master.w_data) + $bits(master.w_strb) + 1 + $bits(master.w_user);
  localparam int B_PW  = MID_W + 2 + $bits(master.b_user);
  localparam int R_PW  = MID_W + $bits(master.r_data) + 3 + $bits(master.r_user);

  if (AW_MODE < 0 || AW_MODE > 2 || W_MODE < 0 || W_MODE > 2 || B_MODE < 0 ||
      B_MODE > 2 || AR_MODE < 0 || AR_MODE > 2 || R_MODE < 0 || R_MODE > 2) begin : g_bad_mode
    $fatal(1, "axi_chan_slice: channel mode outside 0..2");
  end
  if (MID_W > SID_W) begin : g_bad_id
    $fatal(1, "axi_chan_slice: master ID width %0d exceeds slave ID width %0d", MID_W, SID_W);
  end
  if ($bits(master.aw_addr) != $bits(slave.aw_addr) || $bits(master.w_data) != $bits(slave.w_data) ||
      $bits(master.aw_user) != $bits(slave.aw_user) || $bits(master.w_user) != $bits(slave.w_user) ||
      $bits(master.b_user) != $bits(slave.b_user) || $bits(master.ar_user) != $bits(slave.ar_user) ||
      $bits(master.r_user) != $bits(slave.r_user)) begin : g_bad_width
    $fatal(1, "axi_chan_slice: addr/data/user width mismatch between sides");
  end

  logic [AW_PW-1:0] aw_up, aw_dn;
  logic [W_PW-1:0]  w_up, w_dn;
  logic [B_PW-1:0]  b_up, b_dn;
  logic [AR_PW-1:0] ar_up, ar_dn;
  logic [R_PW-1:0]  r_up, r_dn;
  logic             unused_id_hi;

  // IDs are resized before the stages so only the needed width is registered
  assign aw_up = {SID_W'(master.aw_id), master.aw_addr, master.aw_len, master.aw_size,
                  master.aw_burst, master.aw_lock, master.aw_cache, master.aw_prot,
                  master.aw_qos, master.aw_region, master.aw_user};
  assign {slave.aw_id, slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst,
          slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos, slave.aw_region,
          slave.aw_user} = aw_dn;

  assign w_up = {master.w_data, master.w_strb, master.w_last, master.w_user};
  assign {slave.w_data, slave.w_strb, slave.w_last, slave.w_user} = w_dn;

  assign b_up = {slave.b_id[MID_W-1:0], slave.b_resp, slave.b_user};
  assign {master.b_id, master.b_resp, master.b_user} = b_dn;

  assign ar_up = {SID_W'(master.ar_id), master.ar_addr, master.ar_len, master.ar_size,
                  master.ar_burst, master.ar_lock, master.ar_cache, master.ar_prot,
                  master.ar_qos, master.ar_region, master.ar_user};
  assign {slave.ar_id, slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst,
          slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos, slave.ar_region,
          slave.ar_user} = ar_dn;

  assign r_up = {slave.r_id[MID_W-1:0], slave.r_data, slave.r_resp, slave.r_last, slave.r_user};
  assign {master.r_id, master.r_data, master.r_resp, master.r_last, master.r_user} = r_dn;

  assign unused_id_hi = ^{slave.b_id, slave.r_id};

  axi_chan_slice_stage #(.MODE(AW_MODE), .W(AW_PW)) u_aw (
    .clk(clk), .rst(rst),
    .up_valid(master.aw_valid), .up_ready(master.aw_ready), .up_data(aw_up),
    .dn_valid(slave.aw_valid),  .dn_ready(slave.aw_ready),  .dn_data(aw_dn));

  axi_chan_slice_stage #(.MODE(W_MODE), .W(W_PW)) u_w (
    .clk(clk), .rst(rst),
    .up_valid(master.w_valid), .up_ready(master.w_ready), .up_data(w_up),
    .dn_valid(slave.w_valid),  .dn_ready(slave.w_ready),  .dn_data(w_dn));

  axi_chan_slice_stage #(.MODE(B_MODE), .W(B_PW)) u_b (
    .clk(clk), .rst(rst),
    .up_valid(slave.b_valid),  .up_ready(slave.b_ready),  .up_data(b_up),
    .dn_valid(master.b_valid), .dn_ready(master.b_ready), .dn_data(b_dn));

  axi_chan_slice_stage #(.MODE(AR_MODE), .W(AR_PW)) u_ar (
    .clk(clk), .rst(rst),
    .up_valid(master.ar_valid), .up_ready(master.ar_ready), .up_data(ar_up),
    .dn_valid(slave.ar_valid),  .dn_ready(slave.ar_ready),  .dn_data(ar_dn));

  axi_chan_slice_stage #(.MODE(R_MODE), .W(R_PW)) u_r (
    .clk(clk), .rst(rst),
    .up_valid(slave.r_valid),  .up_ready(slave.r_ready),  .up_data(r_up),
    .dn_valid(master.r_valid), .dn_ready(master.r_ready), .dn_data(r_dn));

endmodule

`default_nettype wire

// File: tb/tb_axi_chan_slice.sv
// ============================================================================
// tb_axi_chan_slice - randomized scoreboard bench over skid, forward and bypass
// builds of axi_chan_slice (master ID 4 bits, slave ID 6 bits).  Rev 1.0
// ============================================================================
`default_nettype none

`define AXW(I) I.aw_addr, I.aw_len, I.aw_size, I.aw_burst, I.aw_lock, I.aw_cache, I.aw_prot, I.aw_qos, I.aw_region, I.aw_user
`define AXR(I) I.ar_addr, I.ar_len, I.ar_size, I.ar_burst, I.ar_lock, I.ar_cache, I.ar_prot, I.ar_qos, I.ar_region, I.ar_user
`define WF(I) I.w_data, I.w_strb, I.w_last, I.w_user
`define RF(I) I.r_data, I.r_resp, I.r_last, I.r_user

`define HOOK(D, M, S) \
  assign {M.aw_id, `AXW(M)} = src_pl[D][0][50:0]; \
  assign M.aw_valid = src_v[D][0]; \
  assign S.aw_ready = snk_r[D][0]; \
  assign up_r[D][0] = M.aw_ready; \
  assign dn_v[D][0] = S.aw_valid; \
  assign up_pl[D][0] = 64'({2'b00, M.aw_id, `AXW(M)}); \
  assign dn_pl[D][0] = 64'({S.aw_id, `AXW(S)}); \
  assign {`WF(M)} = src_pl[D][1][20:0]; \
  assign M.w_valid = src_v[D][1]; \
  assign S.w_ready = snk_r[D][1]; \
  assign up_r[D][1] = M.w_ready; \
  assign dn_v[D][1] = S.w_valid; \
  assign up_pl[D][1] = 64'({`WF(M)}); \
  assign dn_pl[D][1] = 64'({`WF(S)}); \
  assign {S.b_id, S.b_resp, S.b_user} = src_pl[D][2][9:0]; \
  assign S.b_valid = src_v[D][2]; \
  assign M.b_ready = snk_r[D][2]; \
  assign up_r[D][2] = S.b_ready; \
  assign dn_v[D][2] = M.b_valid; \
  assign up_pl[D][2] = 64'({S.b_id[3:0], S.b_resp, S.b_user}); \
  assign dn_pl[D][2] = 64'({M.b_id, M.b_resp, M.b_user}); \
  assign {M.ar_id, `AXR(M)} = src_pl[D][3][50:0]; \
  assign M.ar_valid = src_v[D][3]; \
  assign S.ar_ready = snk_r[D][3]; \
  assign up_r[D][3] = M.ar_ready; \
  assign dn_v[D][3] = S.ar_valid; \
  assign up_pl[D][3] = 64'({2'b00, M.ar_id, `AXR(M)}); \
  assign dn_pl[D][3] = 64'({S.ar_id, `AXR(S)}); \
  assign {S.r_id, `RF(S)} = src_pl[D][4][26:0]; \
  assign S.r_valid = src_v[D][4]; \
  assign M.r_ready = snk_r[D][4]; \
  assign up_r[D][4] = S.r_ready; \
  assign dn_v[D][4] = M.r_valid; \
  assign up_pl[D][4] = 64'({S.r_id[3:0], `RF(S)}); \
  assign dn_pl[D][4] = 64'({M.r_id, `RF(M)});

module tb_axi_chan_slice;

  localparam int NC = 5;
  localparam int ND = 3;
  localparam int MODE [ND] = '{2, 1, 0};

  logic clk;
  logic rst;
  logic model_en;
  int   seq_n;
  int   n_chk;
  int   n_fail;

  logic [63:0] src_pl [ND][NC];
  logic        src_v  [ND][NC];
  logic        snk_r  [ND][NC];
  logic        fire   [ND*NC];
  logic [63:0] q      [ND*NC][$];
  wire         up_r   [ND][NC];
  wire         dn_v   [ND][NC];
  wire  [63:0] up_pl  [ND][NC];
  wire  [63:0] dn_pl  [ND][NC];

  axi_channel #(.ID_W(4), .ADDR_W(16), .DATA_W(16), .USER_W(2)) m0 ();
  axi_channel #(.ID_W(6), .ADDR_W(16), .DATA_W(16), .USER_W(2)) s0 ();
  axi_channel #(.ID_W(4), .ADDR_W(16), .DATA_W(16), .USER_W(2)) m1 ();
  axi_channel #(.ID_W(6), .ADDR_W(16), .DATA_W(16), .USER_W(2)) s1 ();
  axi_channel #(.ID_W(4), .ADDR_W(16), .DATA_W(16), .USER_W(2)) m2 ();
  axi_channel #(.ID_W(6), .ADDR_W(16), .DATA_W(16), .USER_W(2)) s2 ();

  axi_chan_slice u_skid (.clk(clk), .rst(rst), .master(m0), .slave(s0));
  axi_chan_slice #(.AW_MODE(1), .W_MODE(1), .B_MODE(1), .AR_MODE(1), .R_MODE(1))
    u_fwd (.clk(clk), .rst(rst), .master(m1), .slave(s1));
  axi_chan_slice #(.AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0))
    u_byp (.clk(clk), .rst(rst), .master(m2), .slave(s2));

  `HOOK(0, m0, s0)
  `HOOK(1, m1, s1)
  `HOOK(2, m2, s2)

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Registered builds: outputs idle, ready high and payload zero under reset
  task automatic rst_checks();
    for (int d = 0; d < ND; d++) begin
      if (MODE[d] != 0) begin
        for (int c = 0; c < NC; c++) begin
          string t;
          t = $sformatf("d%0d_c%0d", d, c);
          chk({t, "_rst_valid"}, 64'(dn_v[d][c]), 64'd0);
          chk({t, "_rst_ready"}, 64'(up_r[d][c]), 64'd1);
          chk({t, "_rst_data"}, dn_pl[d][c], 64'd0);
        end
      end
    end
  endtask

  // Scoreboard: each queue holds the beats accepted but not yet delivered
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        int    k;
        int    n;
        string t;
        k = d * NC + c;
        if (!model_en) begin
          fire[k] = 1'b0;
        end else begin
          n = q[k].size();
          t = $sformatf("d%0d_c%0d", d, c);
          fire[k] = src_v[d][c] && up_r[d][c];
          if (MODE[d] == 0) begin
            chk({t, "_byp_valid"}, 64'(dn_v[d][c]), 64'(src_v[d][c]));
            chk({t, "_byp_ready"}, 64'(up_r[d][c]), 64'(snk_r[d][c]));
            chk({t, "_byp_data"}, dn_pl[d][c], up_pl[d][c]);
          end else begin
            chk({t, "_out_valid"}, 64'(dn_v[d][c]), 64'(n != 0));
            if (MODE[d] == 1)
              chk({t, "_in_ready"}, 64'(up_r[d][c]), 64'(n == 0 || snk_r[d][c]));
            else
              chk({t, "_in_ready"}, 64'(up_r[d][c]), 64'(n < 2));
            if (dn_v[d][c] && n > 0) begin
              chk({t, "_head"}, dn_pl[d][c], q[k][0]);
              if (snk_r[d][c]) void'(q[k].pop_front());
            end
            if (fire[k]) q[k].push_back(up_pl[d][c]);
          end
        end
      end
    end
  end

  // pv/pr: percent chance of valid/ready; pr < 0 toggles ready every cycle
  task automatic step(input int pv, input int pr);
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        if (!src_v[d][c] || fire[d * NC + c]) begin
          src_v[d][c]  = (int'($urandom_range(99)) < pv);
          src_pl[d][c] = {$urandom, $urandom};
          if (d == 0 && c == 0 && src_v[d][c] && seq_n < 16) begin
            src_pl[0][0][46:31] = 16'h1000 + 16'(4 * seq_n);
            seq_n++;
          end
        end
        snk_r[d][c] = (pr < 0) ? !snk_r[d][c] : (int'($urandom_range(99)) < pr);
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    seq_n    = 0;
    model_en = 1'b0;
    rst      = 1'b1;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        src_v[d][c]  = 1'b1;
        src_pl[d][c] = {$urandom, $urandom};
        snk_r[d][c]  = 1'b1;
      end
    end

    repeat (3) begin
      @(negedge clk);
      rst_checks();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_en = 1'b1;

    repeat (24) step(100, 100);
    repeat (400) step(70, 60);
    repeat (200) step(90, 20);
    repeat (100) step(80, -1);

    // asynchronous reset mid-traffic: buffered beats are dropped
    @(posedge clk);
    #3 rst = 1'b1;
    model_en = 1'b0;
    for (int k = 0; k < ND * NC; k++) q[k].delete();
    repeat (2) begin
      @(negedge clk);
      rst_checks();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_en = 1'b1;

    repeat (200) step(60, 50);
    repeat (12) step(0, 100);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        if (MODE[d] != 0)
          chk($sformatf("d%0d_c%0d_drain", d, c), 64'(q[d * NC + c].size()), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`undef HOOK
`undef AXW
`undef AXR
`undef WF
`undef RF

`default_nettype wire
